credits_scroller: RTL and testbench

CREDITS_SCROLLER -- requirements
Module: credits_scroller

---
 rtl/credits_pkg.sv | 30 +++
 rtl/credits_scroller_if.sv | 32 +++
 rtl/credits_hold_timer.sv | 31 +++
 rtl/credits_scroller.sv | 154 +++++++++++++++
 tb/tb_credits_scroller.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/credits_pkg.sv
// Shared types and constants for the credits scroller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package credits_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int LCD_COLS = 16;
    localparam int LCD_ROWS = 2;

    localparam logic [6:0] ASCII_BLANK = 7'h20;

    // ROM line shown on a given LCD row: (top + row) wrapped into 0..num_lines-1.
    // top is always below num_lines, so one conditional subtract is enough.
    function automatic logic [3:0] line_of(input logic [3:0] top, input logic row,
                                           input int num_lines);
        logic [4:0] sum;
        sum = {1'b0, top} + {4'b0000, row};
        if (int'(sum) >= num_lines) begin
            sum = sum - 5'(num_lines);
        end
        return sum[3:0];
    endfunction

endpackage

// File: rtl/credits_scroller_if.sv
// Char ROM lookup plus LCD character-write channel of the credits scroller.
// Latency: n/a (wiring only); rom_code is expected combinationally from rom_addr.
// Backpressure: lcd_valid/lcd_ready, payload held by the master until accepted.
interface credits_scroller_if;
    logic [7:0] rom_addr;
    logic [6:0] rom_code;
    logic       lcd_valid;
    logic       lcd_ready;
    logic       lcd_row;
    logic [3:0] lcd_col;
    logic [6:0] lcd_char;

    modport master (
        output rom_addr,
        input  rom_code,
        output lcd_valid,
        input  lcd_ready,
        output lcd_row,
        output lcd_col,
        output lcd_char
    );

    modport slave (
        input  rom_addr,
        output rom_code,
        input  lcd_valid,
        output lcd_ready,
        input  lcd_row,
        input  lcd_col,
        input  lcd_char
    );
endinterface

// File: rtl/credits_hold_timer.sv
// Screen hold timer: expire is high in the last of HOLD_CYCLES enabled cycles.
// Latency: expire is combinational from the count, HOLD_CYCLES enabled cycles after clear.
// Backpressure: none; counts only while enable is high, clear has priority.
module credits_hold_timer #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int             W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [W-1:0]   LAST = W'(HOLD_CYCLES - 1);

    logic [W-1:0] cnt;

    // Free count while enabled, wrapping at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/credits_scroller.sv
// Credits scroller: streams ROM text lines to a 2x16 LCD, one screen then a hold, then scroll.
// Latency: first LCD write 2 cycles after start, then one character per 2 cycles.
// Backpressure: lcd_valid held with stable row/col/char until lcd_ready; stop waits for it.
module credits_scroller
    import credits_pkg::*;
#(
    parameter int NUM_LINES   = 6,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int LOOP        = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    credits_scroller_if.master bus,
    output logic               busy,
    output logic               done
);
    localparam logic [3:0] LAST_COL  = 4'(LCD_COLS - 1);
    localparam logic       LAST_ROW  = 1'(LCD_ROWS - 1);
    localparam logic [3:0] LAST_LINE = 4'(NUM_LINES - 1);

    state_t     state, state_nxt;
    logic [3:0] top, top_nxt, top_inc;
    logic       row, row_nxt;
    logic [3:0] col, col_nxt;
    logic       stop_pend, stop_pend_nxt;
    logic       done_nxt;
    logic       hs;
    logic       hold_expire;

    assign hs            = bus.lcd_valid && bus.lcd_ready;
    assign top_inc       = (top == LAST_LINE) ? 4'd0 : top + 4'd1;
    assign bus.lcd_valid = (state == SEND);
    assign busy          = (state != IDLE);

    credits_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != HOLD),
        .enable (state == HOLD),
        .expire (hold_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next screen position; a stop seen in SEND is remembered until accepted.
    always_comb begin
        state_nxt     = state;
        top_nxt       = top;
        row_nxt       = row;
        col_nxt       = col;
        stop_pend_nxt = stop_pend;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    top_nxt       = 4'd0;
                    row_nxt       = 1'b0;
                    col_nxt       = 4'd0;
                    stop_pend_nxt = 1'b0;
                    state_nxt     = FETCH;
                end
            end
            FETCH: begin
                if (stop) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (stop) begin
                    stop_pend_nxt = 1'b1;
                end
                if (hs) begin
                    if (stop || stop_pend) begin
                        stop_pend_nxt = 1'b0;
                        done_nxt      = 1'b1;
                        state_nxt     = IDLE;
                    end else if (col != LAST_COL) begin
                        col_nxt   = col + 4'd1;
                        state_nxt = FETCH;
                    end else if (row != LAST_ROW) begin
                        row_nxt   = 1'b1;
                        col_nxt   = 4'd0;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (stop) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (hold_expire) begin
                    top_nxt = top_inc;
                    if (LOOP == 0 && top_inc == 4'd0) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        row_nxt   = 1'b0;
                        col_nxt   = 4'd0;
                        state_nxt = FETCH;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Position, done pulse, ROM address (set on entry to FETCH) and LCD payload (latched in FETCH).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top          <= 4'd0;
            row          <= 1'b0;
            col          <= 4'd0;
            stop_pend    <= 1'b0;
            done         <= 1'b0;
            bus.rom_addr <= 8'd0;
            bus.lcd_row  <= 1'b0;
            bus.lcd_col  <= 4'd0;
            bus.lcd_char <= ASCII_BLANK;
        end else begin
            top       <= top_nxt;
            row       <= row_nxt;
            col       <= col_nxt;
            stop_pend <= stop_pend_nxt;
            done      <= done_nxt;
            if (state_nxt == FETCH) begin
                bus.rom_addr <= {line_of(top_nxt, row_nxt, NUM_LINES), col_nxt};
            end
            if (state == FETCH) begin
                bus.lcd_char <= bus.rom_code;
                bus.lcd_row  <= row;
                bus.lcd_col  <= col;
            end
        end
    end

endmodule

// File: tb/tb_credits_scroller.sv
// Self-checking bench for credits_scroller with a 6-line credits ROM and an 8-cycle hold.
// Latency: n/a.
// Backpressure: lcd_ready driven by the bench (stalls, stop and reset during SEND).
module tb_credits_scroller;

    localparam logic [127:0] ROM_TXT [6] = '{
        "   CREDITS      ",
        "PRODUCED BY     ",
        "    BUILT BY    ",
        "RTL DESIGN      ",
        "VERIFICATION    ",
        "THANK YOU       "
    };

    typedef struct packed {
        logic        row;
        logic [3:0]  col;
        logic [6:0]  ch;
        logic [31:0] cyc;
    } hs_t;

    typedef struct {
        int         idx;
        logic       row;
        logic [3:0] col;
        logic [6:0] ch;
    } vec_t;

    logic clk;
    logic rst_n;
    logic start, stop, start0, ready;
    logic busy, done, busy0, done0;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   done0_cnt = 0;
    int   hs0_cnt  = 0;
    hs_t  hs_q[$];
    vec_t vecs[12];

    credits_scroller_if bif ();
    credits_scroller_if bif0 ();

    function automatic logic [6:0] rom_char(input int line, input int c);
        logic [127:0] t;
        logic [7:0]   b;
        t = ROM_TXT[line];
        b = t[127 - 8*c -: 8];
        return b[6:0];
    endfunction

    function automatic logic [6:0] rom_fn(input logic [7:0] a);
        if (a[7:4] < 4'd6) return rom_char(int'(a[7:4]), int'(a[3:0]));
        return 7'h20;
    endfunction

    assign bif.rom_code   = rom_fn(bif.rom_addr);
    assign bif0.rom_code  = rom_fn(bif0.rom_addr);
    assign bif.lcd_ready  = ready;
    assign bif0.lcd_ready = 1'b1;

    credits_scroller #(.NUM_LINES(6), .HOLD_CYCLES(8), .LOOP(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .bus(bif.master), .busy(busy), .done(done)
    );

    credits_scroller #(.NUM_LINES(6), .HOLD_CYCLES(8), .LOOP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .stop(1'b0),
        .bus(bif0.master), .busy(busy0), .done(done0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle stamp, handshake capture and done-pulse counting.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bif.lcd_valid && bif.lcd_ready)
            hs_q.push_back({bif.lcd_row, bif.lcd_col, bif.lcd_char, 32'(cyc)});
        if (rst_n && bif0.lcd_valid && bif0.lcd_ready) hs0_cnt <= hs0_cnt + 1;
        if (done)  done_cnt  <= done_cnt + 1;
        if (done0) done0_cnt <= done0_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_hs(input int n, input int budget);
        int k = 0;
        while (hs_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("wait_hs%0d_timeout", n), 32'(hs_q.size() >= n), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!bif.lcd_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_valid_timeout", 32'(bif.lcd_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},    32'(bif.lcd_valid), 32'd0);
        check({tag, "_busy"},     32'(busy),          32'd0);
        check({tag, "_done"},     32'(done),          32'd0);
        check({tag, "_rom_addr"}, 32'(bif.rom_addr),  32'd0);
        check({tag, "_row"},      32'(bif.lcd_row),   32'd0);
        check({tag, "_col"},      32'(bif.lcd_col),   32'd0);
        check({tag, "_char"},     32'(bif.lcd_char),  32'h20);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         start_cyc;
        int         n_before;
        int         k;
        logic [11:0] saved;

        vecs[0]  = '{0,   1'b0, 4'd0,  7'h20};
        vecs[1]  = '{3,   1'b0, 4'd3,  7'h43};
        vecs[2]  = '{9,   1'b0, 4'd9,  7'h53};
        vecs[3]  = '{16,  1'b1, 4'd0,  7'h50};
        vecs[4]  = '{31,  1'b1, 4'd15, 7'h20};
        vecs[5]  = '{32,  1'b0, 4'd0,  7'h50};
        vecs[6]  = '{52,  1'b1, 4'd4,  7'h42};
        vecs[7]  = '{160, 1'b0, 4'd0,  7'h54};
        vecs[8]  = '{179, 1'b1, 4'd3,  7'h43};
        vecs[9]  = '{192, 1'b0, 4'd0,  7'h20};
        vecs[10] = '{195, 1'b0, 4'd3,  7'h43};
        vecs[11] = '{208, 1'b1, 4'd0,  7'h50};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; start0 = 1'b0; ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        check("rst_busy0", 32'(busy0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both scrollers start together; dut0 runs freely to its LOOP=0 end.
        start = 1'b1; start0 = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0; start0 = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);

        // Ready stall of 5 cycles inside the second screen.
        wait_hs(40, 200);
        wait_valid(10);
        saved = {bif.lcd_row, bif.lcd_col, bif.lcd_char};
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bif.lcd_valid), 32'd1);
            check("stall_payload", 32'({bif.lcd_row, bif.lcd_col, bif.lcd_char}), 32'(saved));
        end
        ready = 1'b1;

        wait_hs(212, 1000);
        check("first_hs_latency", 32'(hs_q[0].cyc - 32'(start_cyc)), 32'd2);
        check("screen0_span",     hs_q[31].cyc - hs_q[0].cyc, 32'd62);
        check("hold_gap0",        hs_q[32].cyc - hs_q[31].cyc, 32'd10);
        check("hold_gap1",        hs_q[64].cyc - hs_q[63].cyc, 32'd10);

        // LOOP=0 scroller: one done after the 6th hold, then idle.
        k = 0;
        while (busy0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check("loop0_busy",     32'(busy0),     32'd0);
        check("loop0_done_cnt", 32'(done0_cnt), 32'd1);
        check("loop0_hs_cnt",   32'(hs0_cnt),   32'd192);
        check("loop1_no_done",  32'(done_cnt),  32'd0);

        // Stop while SEND is stalled: handshake first, then done, then idle.
        wait_valid(10);
        ready = 1'b0; stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_valid_held", 32'(bif.lcd_valid), 32'd1);
        check("stop_busy_held",  32'(busy),           32'd1);
        check("stop_no_done",    32'(done),           32'd0);
        @(negedge clk);
        check("stop_valid_held2", 32'(bif.lcd_valid), 32'd1);
        n_before = hs_q.size();
        ready = 1'b1;
        @(negedge clk);
        check("stop_hs_taken", 32'(hs_q.size()),  32'(n_before + 1));
        check("stop_done",     32'(done),         32'd1);
        check("stop_idle",     32'(busy),         32'd0);
        check("stop_valid",    32'(bif.lcd_valid), 32'd0);
        @(negedge clk);
        check("stop_done_end", 32'(done),     32'd0);
        check("stop_done_cnt", 32'(done_cnt), 32'd1);

        // Scoreboard: 32 handshakes per screen, top advancing mod 6 and wrapping to 0.
        for (int i = 0; i < hs_q.size(); i++) begin
            int s, p, t, r, c;
            s = i / 32; p = i % 32; t = s % 6; r = p / 16; c = p % 16;
            check($sformatf("sb_hs%0d", i),
                  32'({hs_q[i].row, hs_q[i].col, hs_q[i].ch}),
                  32'({r[0], c[3:0], rom_char((t + r) % 6, c)}));
        end

        // Hand-computed handshake vectors.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].idx < hs_q.size()) begin
                check($sformatf("vec_hs%0d", vecs[i].idx),
                      32'({hs_q[vecs[i].idx].row, hs_q[vecs[i].idx].col, hs_q[vecs[i].idx].ch}),
                      32'({vecs[i].row, vecs[i].col, vecs[i].ch}));
            end else begin
                check($sformatf("vec_hs%0d_missing", vecs[i].idx), 32'(hs_q.size()), 32'(vecs[i].idx + 1));
            end
        end
        hs_q.delete();

        // start and stop together in IDLE: stop wins.
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("ss_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("ss_busy_later", 32'(busy),         32'd0);
        check("ss_no_done",    32'(done_cnt),     32'd1);
        check("ss_no_hs",      32'(hs_q.size()),  32'd0);

        // Asynchronous reset in the middle of a stalled SEND.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_hs(5, 50);
        wait_valid(10);
        ready = 1'b0;
        check("pre_rst_col_nonzero", 32'(bif.lcd_col != 4'd0), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        check_reset_outputs("rst_hold");
        rst_n = 1'b1; ready = 1'b1;
        hs_q.delete();
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);

        // Clean restart after reset.
        start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_hs(1, 20);
        if (hs_q.size() > 0) begin
            check("restart_latency", 32'(hs_q[0].cyc - 32'(start_cyc)), 32'd2);
            check("restart_first",   32'({hs_q[0].row, hs_q[0].col, hs_q[0].ch}),
                  32'({1'b0, 4'd0, 7'h20}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
